// File: rtl/cpu_cycle_ctrl.sv
// Instruction-cycle sequencer driven by a 15-strobe phase generator (ph[0]..ph[14]).
// Define CYCLE_CTRL_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retired is tied to 0.
module cpu_cycle_ctrl #(
  parameter int RET_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [14:0]      ph,
  input  logic             run,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             ir_load,
  output logic             dec_en,
  output logic             alu_en,
  output logic             reg_wr,
  output logic             pc_inc,
  output logic             retry,
  output logic             seq_err,
  output logic             busy,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    COMMIT,
    RETRY
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  last_idx;
  logic [3:0]  strobe_idx;
  logic [3:0]  expect_idx;
  logic        strobe_any;
  logic        strobe_multi;
  logic        seq_bad;
  logic        ir_load_next;
  logic        dec_en_next;
  logic        alu_en_next;
  logic        reg_wr_next;
  logic        pc_inc_next;
  logic        retry_next;

  // A strobe is legal only when it is the single successor of the last one seen; reset parks the tracker at 14.
  always_comb begin
    strobe_idx = 4'd0;
    for (int i = 14; i >= 0; i--) begin
      if (ph[i]) strobe_idx = 4'(i);
    end
    expect_idx   = (last_idx == 4'd14) ? 4'd0 : last_idx + 4'd1;
    strobe_any   = |ph;
    strobe_multi = (ph & (ph - 15'd1)) != 15'd0;
    seq_bad      = strobe_any && (strobe_multi || (strobe_idx != expect_idx));
  end

  always_comb begin
    state_next   = state;
    ir_load_next = 1'b0;
    dec_en_next  = 1'b0;
    alu_en_next  = 1'b0;
    reg_wr_next  = 1'b0;
    pc_inc_next  = 1'b0;
    retry_next   = 1'b0;
    if (seq_bad) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ph[0] && run) state_next = FETCH;
        end
        // An ack wins over a coincident ph[4]; a fetch still pending at ph[4] is abandoned.
        FETCH: begin
          if (mem_ack) begin
            state_next   = DECODE;
            ir_load_next = 1'b1;
          end else if (ph[4]) begin
            state_next = RETRY;
            retry_next = 1'b1;
          end
        end
        RETRY: begin
          if (ph[14]) state_next = IDLE;
        end
        DECODE: begin
          if (ph[5]) begin
            state_next  = EXEC;
            dec_en_next = 1'b1;
          end
        end
        EXEC: begin
          if (ph[8]) begin
            state_next  = WB;
            alu_en_next = 1'b1;
          end
        end
        WB: begin
          if (ph[11]) begin
            state_next  = COMMIT;
            reg_wr_next = 1'b1;
          end
        end
        COMMIT: begin
          if (ph[14]) begin
            state_next  = IDLE;
            pc_inc_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_idx <= 4'd14;
      seq_err  <= 1'b0;
      mem_req  <= 1'b0;
      busy     <= 1'b0;
      ir_load  <= 1'b0;
      dec_en   <= 1'b0;
      alu_en   <= 1'b0;
      reg_wr   <= 1'b0;
      pc_inc   <= 1'b0;
      retry    <= 1'b0;
    end else begin
      state <= state_next;
      if (strobe_any) last_idx <= strobe_idx;
      if (seq_bad) seq_err <= 1'b1;
      mem_req <= (state_next == FETCH);
      busy    <= (state_next != IDLE);
      ir_load <= ir_load_next;
      dec_en  <= dec_en_next;
      alu_en  <= alu_en_next;
      reg_wr  <= reg_wr_next;
      pc_inc  <= pc_inc_next;
      retry   <= retry_next;
    end
  end

`ifdef CYCLE_CTRL_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired <= '0;
    end else if (pc_inc_next) begin
      retired <= retired + RET_W'(1);
    end
  end
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_cpu_cycle_ctrl.sv
// Self-checking bench for cpu_cycle_ctrl: directed scenarios plus randomized phase streams
// compared every cycle against a phase-rule model of the instruction cycle.
module tb_cpu_cycle_ctrl;

  localparam int TB_RET_W = 4;  // narrow counter so the wrap is reachable in a short run
`ifdef CYCLE_CTRL_RETIRE_CNT_EN
  localparam bit RET_ON = 1'b1;
`else
  localparam bit RET_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [14:0]         ph = '0;
  logic                run = 1'b0;
  logic                mem_ack = 1'b0;
  logic                mem_req, ir_load, dec_en, alu_en, reg_wr, pc_inc, retry, seq_err, busy;
  logic [TB_RET_W-1:0] retired;

  int checks = 0;
  int errors = 0;
  int cnt_req = 0, cnt_ir = 0, cnt_dec = 0, cnt_alu = 0, cnt_wr = 0, cnt_pc = 0, cnt_retry = 0;
  int s_req, s_ir, s_dec, s_alu, s_wr, s_pc, s_retry;

  cpu_cycle_ctrl #(.RET_W(TB_RET_W)) dut (
    .clk(clk), .reset(reset), .ph(ph), .run(run), .mem_ack(mem_ack),
    .mem_req(mem_req), .ir_load(ir_load), .dec_en(dec_en), .alu_en(alu_en),
    .reg_wr(reg_wr), .pc_inc(pc_inc), .retry(retry), .seq_err(seq_err),
    .busy(busy), .retired(retired)
  );

  always #5 clk = ~clk;

  // Model: where the instruction is (fetching / fetched / retry-wait) plus the last strobe index.
  typedef struct packed {
    int last;
    int ret;
    bit err, fetch, inst, rwait;
    bit ir, dec, alu, wr, pc, rt;
  } model_t;

  model_t m;

  function automatic int lowestSet(input logic [14:0] p);
    for (int i = 0; i < 15; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic model_t stepModel(input model_t cur, input logic [14:0] p, input logic r, input logic a);
    model_t n;
    int     k;
    bit     bad;
    n = cur;
    {n.ir, n.dec, n.alu, n.wr, n.pc, n.rt} = '0;
    k   = lowestSet(p);
    bad = (k >= 0) && (($countones(p) != 1) || (k != (cur.last + 1) % 15));
    if (k >= 0) n.last = k;
    if (bad) begin
      n.err = 1'b1; n.fetch = 1'b0; n.inst = 1'b0; n.rwait = 1'b0;
    end else if (cur.fetch) begin
      if (a) begin
        n.fetch = 1'b0; n.inst = 1'b1; n.ir = 1'b1;
      end else if (k == 4) begin
        n.fetch = 1'b0; n.rwait = 1'b1; n.rt = 1'b1;
      end
    end else if (cur.inst) begin
      n.dec = (k == 5);
      n.alu = (k == 8);
      n.wr  = (k == 11);
      if (k == 14) begin
        n.pc = 1'b1; n.inst = 1'b0; n.ret = cur.ret + 1;
      end
    end else if (cur.rwait) begin
      if (k == 14) n.rwait = 1'b0;
    end else if (k == 0 && r) begin
      n.fetch = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{last: 14, default: '0};
    else       m <= stepModel(m, ph, run, mem_ack);
  end

  logic [8:0] dut_vec, exp_vec;
  assign dut_vec = {mem_req, ir_load, dec_en, alu_en, reg_wr, pc_inc, retry, seq_err, busy};
  assign exp_vec = {m.fetch, m.ir, m.dec, m.alu, m.wr, m.pc, m.rt, m.err, m.fetch | m.inst | m.rwait};

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("outputs{req,ir,dec,alu,wr,pc,retry,err,busy}", 32'(dut_vec), 32'(exp_vec));
    checkOutput("retired", 32'(retired), RET_ON ? (m.ret % (1 << TB_RET_W)) : 0);
    cnt_req   <= cnt_req + 32'(mem_req);
    cnt_ir    <= cnt_ir + 32'(ir_load);
    cnt_dec   <= cnt_dec + 32'(dec_en);
    cnt_alu   <= cnt_alu + 32'(alu_en);
    cnt_wr    <= cnt_wr + 32'(reg_wr);
    cnt_pc    <= cnt_pc + 32'(pc_inc);
    cnt_retry <= cnt_retry + 32'(retry);
  end

  task automatic applyStimulus(input logic [14:0] p, input logic r, input logic a);
    ph = p; run = r; mem_ack = a;
  endtask

  task automatic snap();
    s_req = cnt_req; s_ir = cnt_ir; s_dec = cnt_dec; s_alu = cnt_alu;
    s_wr = cnt_wr; s_pc = cnt_pc; s_retry = cnt_retry;
  endtask

  task automatic settle();
    @(negedge clk);
    applyStimulus(15'd0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    #1 reset = 1'b1;
    applyStimulus(15'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ack_mode: 0 never, 1 after ack_delay cycles of mem_req, 2 random; run_mode: 0 low, 1 high, 2 random.
  task automatic phaseStream(input int first, input int count, input int gap, input int ack_mode,
                             input int ack_delay, input int run_mode, input bit glitch);
    int          req_cycles;
    logic [14:0] p;
    logic        r, a;
    req_cycles = 0;
    for (int s = 0; s < count; s++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        req_cycles = mem_req ? req_cycles + 1 : 0;
        p = (g == 0) ? (15'd1 << (first + s)) : 15'd0;
        if (glitch && $urandom_range(0, 24) == 0) p = 15'($urandom);
        r = (run_mode == 2) ? ($urandom_range(0, 4) != 0) : (run_mode == 1);
        case (ack_mode)
          1:       a = (req_cycles == ack_delay);
          2:       a = ($urandom_range(0, 2) == 0);
          default: a = 1'b0;
        endcase
        applyStimulus(p, r, a);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_outputs", 32'(dut_vec), 0);
    checkOutput("reset_retired", 32'(retired), 0);
    reset = 1'b0;

    snap();
    phaseStream(0, 15, 2, 1, 2, 1, 1'b0);
    settle();
    checkOutput("nominal_ir_load", cnt_ir - s_ir, 1);
    checkOutput("nominal_dec_en", cnt_dec - s_dec, 1);
    checkOutput("nominal_alu_en", cnt_alu - s_alu, 1);
    checkOutput("nominal_reg_wr", cnt_wr - s_wr, 1);
    checkOutput("nominal_pc_inc", cnt_pc - s_pc, 1);
    checkOutput("nominal_retry", cnt_retry - s_retry, 0);
    checkOutput("nominal_busy", 32'(busy), 0);
    checkOutput("nominal_retired", 32'(retired), RET_ON ? 1 : 0);

    snap();
    phaseStream(0, 15, 2, 0, 0, 1, 1'b0);
    settle();
    checkOutput("late_retry", cnt_retry - s_retry, 1);
    checkOutput("late_ir_load", cnt_ir - s_ir, 0);
    checkOutput("late_mem_req", 32'(mem_req), 0);
    checkOutput("late_retired", 32'(retired), RET_ON ? 1 : 0);
    snap();
    phaseStream(0, 15, 2, 1, 2, 1, 1'b0);
    settle();
    checkOutput("refetch_pc_inc", cnt_pc - s_pc, 1);

    snap();
    phaseStream(0, 15, 1, 1, 4, 1, 1'b0);
    settle();
    checkOutput("ack_at_ph4_retry", cnt_retry - s_retry, 0);
    checkOutput("ack_at_ph4_ir_load", cnt_ir - s_ir, 1);
    checkOutput("ack_at_ph4_pc_inc", cnt_pc - s_pc, 1);

    snap();
    phaseStream(0, 15, 2, 1, 2, 0, 1'b0);
    settle();
    checkOutput("run_low_mem_req_cycles", cnt_req - s_req, 0);
    checkOutput("run_low_busy", 32'(busy), 0);

    resetDut();
    snap();
    phaseStream(0, 3, 1, 0, 0, 1, 1'b0);
    @(negedge clk);
    applyStimulus(15'd1 << 5, 1'b1, 1'b0);
    settle();
    checkOutput("skip_seq_err", 32'(seq_err), 1);
    checkOutput("skip_mem_req", 32'(mem_req), 0);
    checkOutput("skip_busy", 32'(busy), 0);
    phaseStream(6, 9, 1, 0, 0, 1, 1'b0);
    settle();
    checkOutput("skip_seq_err_sticky", 32'(seq_err), 1);
    checkOutput("skip_no_retry", cnt_retry - s_retry, 0);

    resetDut();
    @(negedge clk);
    applyStimulus(15'h0003, 1'b1, 1'b0);
    settle();
    checkOutput("multi_seq_err", 32'(seq_err), 1);
    checkOutput("multi_mem_req", 32'(mem_req), 0);

    resetDut();
    @(negedge clk);
    applyStimulus(15'd1 << 3, 1'b1, 1'b0);
    settle();
    checkOutput("first_not_ph0_seq_err", 32'(seq_err), 1);

    resetDut();
    snap();
    phaseStream(0, 7, 2, 1, 2, 1, 1'b0);
    settle();
    checkOutput("midreset_reached_exec", cnt_dec - s_dec, 1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_outputs", 32'(dut_vec), 0);
    checkOutput("midreset_retired", 32'(retired), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    phaseStream(0, 15, 2, 1, 2, 1, 1'b0);
    settle();
    checkOutput("midreset_alu_en", cnt_alu - s_alu, 1);
    checkOutput("midreset_pc_inc", cnt_pc - s_pc, 1);
    checkOutput("midreset_seq_err", 32'(seq_err), 0);

`ifdef CYCLE_CTRL_RETIRE_CNT_EN
    resetDut();
    for (int i = 0; i < 15; i++) phaseStream(0, 15, 1, 1, 2, 1, 1'b0);
    settle();
    checkOutput("wrap_all_ones", 32'(retired), 15);
    phaseStream(0, 15, 1, 1, 2, 1, 1'b0);
    settle();
    checkOutput("wrap_to_zero", 32'(retired), 0);
`endif

    resetDut();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) resetDut();
      phaseStream(0, 15, $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(1, 4),
                  $urandom_range(0, 2), ($urandom_range(0, 2) == 0));
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_cycle_ctrl.md
CPU_CYCLE_CTRL -- requirements
Module: cpu_cycle_ctrl

Interface
REQ-001 Parameter RET_W, default 16: width of the retired-instruction counter.
REQ-002 Clock clk; reset reset, asynchronous, active-high.
REQ-003 clk  input  1  system clock, same clock that drives the phase generator.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 ph  input  15  phase strobes, one-cycle pulses in the order ph[0]..ph[14]:
- phases 1, 2, 3, 4, 4_2, 5, 6, 6_2, 7, 8, 8_2, 9, 10, 11, 12.
REQ-006 run  input  1  level; permits a new instruction to start.
REQ-007 mem_ack  input  1  one-cycle fetch acknowledge.
REQ-008 mem_req  output  1  fetch request level.
REQ-009 ir_load  output  1  instruction register load pulse.
REQ-010 dec_en  output  1  decode pulse.
REQ-011 alu_en  output  1  execute pulse.
REQ-012 reg_wr  output  1  write-back pulse.
REQ-013 pc_inc  output  1  program counter increment pulse.
REQ-014 retry  output  1  fetch-abort pulse.
REQ-015 seq_err  output  1  sticky phase-sequence error flag.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 retired  output  RET_W  count of completed instructions.

Function
REQ-018 States:
- IDLE, FETCH, DECODE, EXEC, WB, COMMIT, RETRY.
REQ-019 All pulse outputs are registered, one cycle wide, and assert the cycle after their triggering strobe or ack.
REQ-020 IDLE -> FETCH on ph[0] with run=1:
- mem_req rises the next cycle.
- ph[0] with run=0 keeps IDLE.
REQ-021 FETCH holds mem_req=1 until mem_ack=1.
REQ-022 mem_ack in FETCH:
- mem_req=0 and ir_load=1 the next cycle.
- state -> DECODE.
REQ-023 ph[4] in FETCH with no mem_ack:
- retry pulse; mem_req drops; state -> RETRY.
REQ-024 RETRY -> IDLE on ph[14]:
- mem_ack in RETRY is discarded.
- the fetch restarts at the next ph[0] if run=1.
REQ-025 DECODE -> EXEC on ph[5], pulsing dec_en.
REQ-026 EXEC -> WB on ph[8], pulsing alu_en.
REQ-027 WB -> COMMIT on ph[11], pulsing reg_wr.
REQ-028 COMMIT -> IDLE on ph[14]:
- pc_inc pulses.
- retired increments, wrapping from all-ones to 0.
REQ-029 mem_ack and a phase strobe in the same FETCH cycle: ack has priority; no retry.
REQ-030 mem_ack outside FETCH is ignored.
REQ-031 run deasserted mid-instruction: the current instruction completes; no new start.
REQ-032 Phase tracker: holds the index of the last strobe seen.
REQ-033 Sequence error condition:
- more than one ph bit set in a cycle, or
- a strobe that is not the successor of the last seen index (14 wraps to 0).
REQ-034 On a sequence error:
- seq_err=1 (sticky).
- state -> IDLE; mem_req=0; no pulse issued that cycle.
- tracker resynchronises to the offending strobe index; with multiple bits set, it takes the lowest set index.
REQ-035 The first strobe after reset is accepted only if it is ph[0]; any other first strobe sets seq_err.

Reset
REQ-036 Reset, asynchronously:
- all outputs to 0, retired to 0, seq_err to 0.
- state to IDLE; tracker to "expect ph[0]".
REQ-037 Reset mid-instruction:
- aborts with no pulse issued and no retired increment.
- mem_req drops immediately.

Configuration
REQ-038 Macro CYCLE_CTRL_RETIRE_CNT_EN:
- defined: the retired counter is implemented per REQ-028.
- undefined: retired is tied to 0, with no counter flops; all other behaviour is unchanged.

Verification
REQ-039 Nominal instruction:
- stimulus: run=1, 30-cycle phase stream, mem_ack two cycles after mem_req.
- response: pulses in order ir_load, dec_en, alu_en, reg_wr, pc_inc; retired=1; busy low after pc_inc.
REQ-040 Late ack:
- stimulus: mem_ack withheld past ph[4].
- response: retry=1 for one cycle; mem_req=0; no ir_load; retired unchanged; refetch at next ph[0].
REQ-041 Sequence errors:
- stimulus: ph[5] injected directly after ph[2]; ph=15'h0003 in one cycle.
- response: seq_err=1 (sticky); state IDLE; mem_req=0.
REQ-042 Wrap:
- stimulus: with the macro defined, retired preloaded to 16'hFFFF via 65535 instructions, then one more instruction.
- response: retired=16'h0000.
REQ-043 Mid-operation reset:
- stimulus: reset asserted in EXEC.
- response: all outputs 0 the same cycle; no alu_en; the first ph[0] after release starts cleanly with seq_err=0.
REQ-044 Run and ack edge cases:
- stimulus: run=0 at ph[0]; mem_ack coincident with ph[4].
- response: no mem_req; fetch succeeds with no retry.
